// File: rtl/wb_write_sequencer_pkg.sv
// Package: wb_write_sequencer_pkg
// Purpose: shared Y86 constants for the writeback sequencer. Holds the stat codes,
//          the "no register" address, icode constants, the sequencer state enum and a
//          helper that maps a terminating stat onto the status that is latched.
package wb_write_sequencer_pkg;

  // Status codes carried by every pipeline record
  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  // Register address meaning "no destination"
  localparam logic [3:0] RNONE = 4'hF;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Sequencer states
  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_HALTED = 2'd2
  } ws_state_t;

  // SHLT and SADR are kept as-is; anything else that terminates is reported as SINS
  function automatic logic [2:0] final_stat(input logic [2:0] stat);
    if ((stat == SHLT) || (stat == SADR)) begin
      return stat;
    end
    return SINS;
  endfunction

endpackage

// File: rtl/wb_write_sequencer_if.sv
// Interface: wb_write_sequencer_if
// Purpose: bundles the W-stage record, the regfile write port and the status outputs of
//          the writeback sequencer.
// Modports:
//   master - pipeline side: drives the W_* record, observes write port and status
//   slave  - sequencer side: consumes the W_* record, drives write port and status
interface wb_write_sequencer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 32
);

  // W-stage record
  logic [3:0]        W_icode;
  logic [2:0]        W_stat;
  logic [REG_AW-1:0] W_dstE;
  logic [REG_AW-1:0] W_dstM;
  logic [DATA_W-1:0] W_valE;
  logic [DATA_W-1:0] W_valM;

  // Regfile write port and pipeline control
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              W_stall_req;

  // Program status
  logic              halt;
  logic [2:0]        prog_stat;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output W_icode, W_stat, W_dstE, W_dstM, W_valE, W_valM,
    input  rf_we, rf_waddr, rf_wdata, W_stall_req, halt, prog_stat, retire_cnt
  );

  modport slave (
    input  W_icode, W_stat, W_dstE, W_dstM, W_valE, W_valM,
    output rf_we, rf_waddr, rf_wdata, W_stall_req, halt, prog_stat, retire_cnt
  );

endinterface

// File: rtl/wb_write_sequencer.sv
// Module: wb_write_sequencer
// Purpose: drains W-stage records into a single-write-port regfile. A record with two
//          distinct destinations takes two cycles (E first, then M, with W stalled for
//          the first); terminating status freezes the pipeline until reset.
// Ports:
//   clk    - pipeline clock
//   reset  - synchronous, active-high reset
//   bus    - slave modport: W_* record in; rf_we/rf_waddr/rf_wdata, W_stall_req,
//            halt, prog_stat, retire_cnt out
module wb_write_sequencer
  import wb_write_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_write_sequencer_if.slave  bus
);

  localparam logic [REG_AW-1:0] RegNone = '1;

  ws_state_t         r_state;
  ws_state_t         w_state_d;
  logic              r_halt;
  logic [2:0]        r_prog_stat;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_stall;
  logic              w_retire;
  logic              w_terminate;
  logic              w_has_e;
  logic              w_has_m;
  logic              w_unused_icode;

  // icode plays no part in writeback sequencing
  assign w_unused_icode = ^bus.W_icode;

  assign w_has_e = (bus.W_dstE != RegNone);
  assign w_has_m = (bus.W_dstM != RegNone);

  // Next state and write port; idle bus is RNONE/0 so it is always deterministic
  always_comb begin
    w_state_d   = r_state;
    w_we        = 1'b0;
    w_waddr     = RegNone;
    w_wdata     = '0;
    w_stall     = 1'b0;
    w_retire    = 1'b0;
    w_terminate = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FIRST: begin
          if (bus.W_stat == SBUB) begin
            w_state_d = S_FIRST;
          end else if (bus.W_stat == SAOK) begin
            w_retire = 1'b1;
            if (w_has_e && w_has_m && (bus.W_dstE != bus.W_dstM)) begin
              // E goes first so valM is the last value written on any overlap
              w_we      = 1'b1;
              w_waddr   = bus.W_dstE;
              w_wdata   = bus.W_valE;
              w_stall   = 1'b1;
              w_retire  = 1'b0;
              w_state_d = S_SECOND;
            end else if (w_has_m) begin
              // Same-register case lands here too: valM wins
              w_we    = 1'b1;
              w_waddr = bus.W_dstM;
              w_wdata = bus.W_valM;
            end else if (w_has_e) begin
              w_we    = 1'b1;
              w_waddr = bus.W_dstE;
              w_wdata = bus.W_valE;
            end
          end else begin
            w_terminate = 1'b1;
            w_state_d   = S_HALTED;
          end
        end
        S_SECOND: begin
          w_we      = 1'b1;
          w_waddr   = bus.W_dstM;
          w_wdata   = bus.W_valM;
          w_retire  = 1'b1;
          w_state_d = S_FIRST;
        end
        S_HALTED: begin
          w_stall = 1'b1;
        end
        default: begin
          w_state_d = S_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FIRST;
      r_halt       <= 1'b0;
      r_prog_stat  <= SAOK;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_terminate) begin
        r_halt      <= 1'b1;
        r_prog_stat <= final_stat(bus.W_stat);
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.rf_we       = w_we;
  assign bus.rf_waddr    = w_waddr;
  assign bus.rf_wdata    = w_wdata;
  assign bus.W_stall_req = w_stall;
  assign bus.halt        = r_halt;
  assign bus.prog_stat   = r_prog_stat;
  assign bus.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Testbench for wb_write_sequencer: directed records followed by random records, each
// compared against a record-level model that lists the writes a record must produce.
module tb_wb_write_sequencer;
  import wb_write_sequencer_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_write_sequencer_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  wb_write_sequencer #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: program-level status
  int unsigned m_cnt;
  logic        m_halt;
  logic [2:0]  m_stat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic we, input logic [3:0] addr,
                            input logic [63:0] data, input logic stall);
    chk({tag, ".rf_we"}, 64'(bus.rf_we), 64'(we));
    chk({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(addr));
    chk({tag, ".rf_wdata"}, bus.rf_wdata, data);
    chk({tag, ".stall"}, 64'(bus.W_stall_req), 64'(stall));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".halt"}, 64'(bus.halt), 64'(m_halt));
    chk({tag, ".prog_stat"}, 64'(bus.prog_stat), 64'(m_stat));
    chk({tag, ".retire_cnt"}, 64'(bus.retire_cnt), 64'(m_cnt % (1 << CW)));
  endtask

  task automatic apply(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    @(negedge clk);
    bus.W_stat  = stat;
    bus.W_icode = icode;
    bus.W_dstE  = de;
    bus.W_dstM  = dm;
    bus.W_valE  = ve;
    bus.W_valM  = vm;
  endtask

  // Reset with a bubble in W; leaves the bench just after a negedge with reset released
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset      = 1'b1;
    bus.W_stat = SBUB;
    #1 check_port({tag, ".rst"}, 1'b0, RNONE, 64'h0, 1'b0);
    @(posedge clk);
    m_cnt  = 0;
    m_halt = 1'b0;
    m_stat = SAOK;
    #1 check_regs({tag, ".rst"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one record and hold it for as many cycles as the sequencer needs
  task automatic run_record(input string tag, input logic [2:0] stat, input logic [3:0] icode,
                            input logic [3:0] de, input logic [3:0] dm,
                            input logic [63:0] ve, input logic [63:0] vm);
    logic [3:0]  wa[$];
    logic [63:0] wd[$];
    int          ncyc;
    apply(stat, icode, de, dm, ve, vm);
    if (m_halt) begin
      #1 check_port(tag, 1'b0, RNONE, 64'h0, 1'b1);
      @(posedge clk);
      #1 check_regs(tag);
    end else if (stat == SBUB) begin
      #1 check_port(tag, 1'b0, RNONE, 64'h0, 1'b0);
      @(posedge clk);
      #1 check_regs(tag);
    end else if (stat == SAOK) begin
      if (de != RNONE && dm != RNONE && de != dm) begin
        wa.push_back(de); wd.push_back(ve);
        wa.push_back(dm); wd.push_back(vm);
      end else if (dm != RNONE) begin
        wa.push_back(dm); wd.push_back(vm);
      end else if (de != RNONE) begin
        wa.push_back(de); wd.push_back(ve);
      end
      ncyc = (wa.size() == 0) ? 1 : wa.size();
      for (int i = 0; i < ncyc; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        if (i < wa.size()) check_port(tag, 1'b1, wa[i], wd[i], (i < ncyc - 1));
        else check_port(tag, 1'b0, RNONE, 64'h0, 1'b0);
        @(posedge clk);
        if (i == ncyc - 1) m_cnt++;
        #1 check_regs(tag);
      end
    end else begin
      #1 check_port(tag, 1'b0, RNONE, 64'h0, 1'b0);
      @(posedge clk);
      m_halt = 1'b1;
      m_stat = (stat == SHLT || stat == SADR) ? stat : SINS;
      #1 check_regs(tag);
    end
  endtask

  function automatic logic [3:0] rnd_reg();
    int unsigned r;
    r = $urandom_range(0, 5);
    return (r >= 4) ? RNONE : 4'(r);
  endfunction

  initial begin
    logic [2:0] st;
    int unsigned r;
    reset = 1'b1;
    bus.W_stat = SBUB; bus.W_icode = INOP; bus.W_dstE = RNONE; bus.W_dstM = RNONE;
    bus.W_valE = '0; bus.W_valM = '0;
    m_cnt = 0; m_halt = 1'b0; m_stat = SAOK;
    repeat (2) @(posedge clk);
    #1 check_regs("reset");
    check_port("reset", 1'b0, RNONE, 64'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1. irmovq
    run_record("irmovq", SAOK, IIRMOVQ, 4'h3, RNONE, 64'h10, 64'h0);
    // 2. popq %rbx: two writes, one retire
    run_record("popq_rbx", SAOK, IPOPQ, 4'h4, 4'h3, 64'h108, 64'hAA);
    // 3. popq %rsp: single write, valM wins
    run_record("popq_rsp", SAOK, IPOPQ, 4'h4, 4'h4, 64'h108, 64'h55);
    run_record("bubble", SBUB, INOP, 4'h1, 4'h2, 64'h1, 64'h2);

    // 4. SADR terminates and freezes
    run_record("sadr", SADR, IMRMOVQ, RNONE, 4'h2, 64'h0, 64'h77);
    for (int i = 0; i < 10; i++) begin
      run_record("halted", 3'($urandom_range(0, 7)), 4'($urandom), rnd_reg(), rnd_reg(),
                 {$urandom, $urandom}, {$urandom, $urandom});
    end
    do_reset("exit_halt");

    // 5. Reset during the second cycle of a two-write record
    apply(SAOK, IPOPQ, 4'h4, 4'h3, 64'h108, 64'hAA);
    #1 check_port("mid_first", 1'b1, 4'h4, 64'h108, 1'b1);
    @(posedge clk);
    #1 check_regs("mid_first");
    @(negedge clk);
    reset = 1'b1;
    #1 check_port("mid_rst", 1'b0, RNONE, 64'h0, 1'b0);
    @(posedge clk);
    m_cnt = 0; m_halt = 1'b0; m_stat = SAOK;
    #1 check_regs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    bus.W_stat = SBUB;

    // 6. Counter wraps at 2^CW; bubbles never count
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      run_record("nop", SAOK, INOP, RNONE, RNONE, 64'h0, 64'h0);
      run_record("nop_bub", SBUB, INOP, RNONE, RNONE, 64'h0, 64'h0);
    end
    chk("cnt_max", 64'(bus.retire_cnt), 64'((1 << CW) - 1));
    run_record("nop_wrap", SAOK, INOP, RNONE, RNONE, 64'h0, 64'h0);
    chk("cnt_wrap", 64'(bus.retire_cnt), 64'h0);

    // Random records, including out-of-range stat values
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 29);
      if (r < 3) st = SBUB;
      else if (r < 27) st = SAOK;
      else st = 3'($urandom_range(2, 7));
      run_record("rand", st, 4'($urandom_range(0, 11)), rnd_reg(), rnd_reg(),
                 {$urandom, $urandom}, {$urandom, $urandom});
      if (m_halt && ($urandom_range(0, 2) == 0)) do_reset("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
